// File: rtl/max7219_display_scheduler_pkg.sv
// Shared definitions for the MAX7219 display scheduler: register addresses,
// state encodings and the power-up init word table.
package max7219_display_scheduler_pkg;

  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIM   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam int unsigned NUM_DIGITS    = 6;
  localparam logic [2:0]  LAST_WORD_IDX = 3'd5;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CFG, ST_FRAME} sched_state_t;
  typedef enum logic [1:0] {PH_WAIT_RDY, PH_SEND, PH_GAP} issue_phase_t;

  // Shutdown first so the panel stays dark while it is being configured.
  function automatic logic [15:0] init_word(input logic [2:0] idx,
                                            input logic [3:0] intensity,
                                            input logic [2:0] scan_limit);
    case (idx)
      3'd0:    init_word = {REG_SHUTDOWN, 8'h00};
      3'd1:    init_word = {REG_TEST, 8'h00};
      3'd2:    init_word = {REG_SCANLIM, 5'b00000, scan_limit};
      3'd3:    init_word = {REG_INTENSITY, 4'b0000, intensity};
      3'd4:    init_word = {REG_DECODE, 8'hFF};
      default: init_word = {REG_SHUTDOWN, 8'h01};
    endcase
  endfunction

endpackage

// File: rtl/max7219_display_scheduler_if.sv
// Handshake bundle between the scheduler (master), the SPI master and the config requester (slave side).
interface max7219_display_scheduler_if;
  logic [15:0] spi_word;
  logic        spi_cs;
  logic        spi_ready;
  logic        spi_sent;
  logic        cfg_req;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_ack;

  modport master (output spi_word, spi_cs, cfg_ack,
                  input  spi_ready, spi_sent, cfg_req, cfg_addr, cfg_data);
  modport slave  (input  spi_word, spi_cs, cfg_ack,
                  output spi_ready, spi_sent, cfg_req, cfg_addr, cfg_data);
endinterface

// File: rtl/max7219_display_scheduler_spi_word_issuer.sv
// Pushes one 16-bit word through the SPI master handshake and enforces the
// inter-word idle gap; issue_done pulses when the next word may be presented.
module max7219_display_scheduler_spi_word_issuer
  import max7219_display_scheduler_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 32
) (
  input  logic        clk,
  input  logic        res,
  input  logic        issue_valid_i,
  input  logic [15:0] issue_word_i,
  output logic        issue_done_o,
  input  logic        spi_ready_i,
  input  logic        spi_sent_i,
  output logic [15:0] spi_word_o,
  output logic        spi_cs_o
);

  // The WAIT_RDY cycle itself is the last high cycle of the gap, so the GAP phase is one shorter.
  localparam bit         HAS_GAP  = (GAP_CYCLES > 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  issue_phase_t phase_q, phase_d;
  logic [7:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]  word_q, word_d;
  logic         cs_q, cs_d;

  always_comb begin
    phase_d      = phase_q;
    gap_cnt_d    = gap_cnt_q;
    word_d       = word_q;
    cs_d         = cs_q;
    issue_done_o = 1'b0;
    case (phase_q)
      PH_WAIT_RDY: begin
        if (issue_valid_i && spi_ready_i) begin
          word_d  = issue_word_i;
          cs_d    = 1'b0;
          phase_d = PH_SEND;
        end
      end
      PH_SEND: begin
        if (spi_sent_i) begin
          cs_d = 1'b1;
          if (HAS_GAP) begin
            phase_d   = PH_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            phase_d      = PH_WAIT_RDY;
            issue_done_o = 1'b1;
          end
        end
      end
      PH_GAP: begin
        gap_cnt_d = gap_cnt_q - 8'd1;
        if (gap_cnt_q == 8'd1) begin
          phase_d      = PH_WAIT_RDY;
          issue_done_o = 1'b1;
        end
      end
      default: phase_d = PH_WAIT_RDY;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      phase_q   <= PH_WAIT_RDY;
      gap_cnt_q <= 8'd0;
      word_q    <= 16'h0000;
      cs_q      <= 1'b1;
    end else begin
      phase_q   <= phase_d;
      gap_cnt_q <= gap_cnt_d;
      word_q    <= word_d;
      cs_q      <= cs_d;
    end
  end

  assign spi_word_o = word_q;
  assign spi_cs_o   = cs_q;

endmodule

// File: rtl/max7219_display_scheduler.sv
// Arbitrates init, config and per-tick time-frame traffic onto one MAX7219 SPI link.
module max7219_display_scheduler
  import max7219_display_scheduler_pkg::*;
#(
  parameter logic [3:0]  INIT_INTENSITY = 4'h8,
  parameter logic [2:0]  SCAN_LIMIT     = 3'd5,
  parameter logic [5:0]  DP_MASK        = 6'b010100,
  parameter int unsigned GAP_CYCLES     = 32
) (
  input  logic       clk,
  input  logic       res,
  input  logic       frame_tick_i,
  input  logic       frame_ena_i,
  input  logic [3:0] ces_0X_i,
  input  logic [3:0] ces_X0_i,
  input  logic [3:0] sec_0X_i,
  input  logic [2:0] sec_X0_i,
  input  logic [3:0] min_0X_i,
  input  logic [2:0] min_X0_i,
  max7219_display_scheduler_if.master bus,
  output logic       init_done_o,
  output logic       busy_o,
  output logic       frame_drop_o
);

  sched_state_t state_q, state_d;
  logic [2:0]   word_idx_q, word_idx_d;
  logic         frame_pend_q, frame_pend_d;
  logic [15:0]  cfg_word_q, cfg_word_d;
  logic         frame_tick_q, cfg_ack_q, init_done_q, busy_q, frame_drop_q;
  logic [3:0]   digit_in [NUM_DIGITS];
  logic [3:0]   digit_q  [NUM_DIGITS];
  logic         tick_rise, frame_grant, cfg_grant, issue_valid, issue_done;
  logic [15:0]  issue_word, frame_word;

  assign digit_in[0] = ces_0X_i;
  assign digit_in[1] = ces_X0_i;
  assign digit_in[2] = sec_0X_i;
  assign digit_in[3] = {1'b0, sec_X0_i};
  assign digit_in[4] = min_0X_i;
  assign digit_in[5] = {1'b0, min_X0_i};

  assign tick_rise  = frame_tick_i & ~frame_tick_q & frame_ena_i;
  assign frame_word = {8'(word_idx_q) + 8'd1, DP_MASK[word_idx_q], 3'b000, digit_q[word_idx_q]};

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    frame_pend_d = frame_pend_q;
    cfg_word_d   = cfg_word_q;
    frame_grant  = 1'b0;
    cfg_grant    = 1'b0;
    issue_valid  = 1'b0;
    issue_word   = 16'h0000;
    if (tick_rise && !frame_pend_q) frame_pend_d = 1'b1;
    case (state_q)
      ST_INIT: begin
        issue_valid = 1'b1;
        issue_word  = init_word(word_idx_q, INIT_INTENSITY, SCAN_LIMIT);
        if (issue_done) begin
          word_idx_d = (word_idx_q == LAST_WORD_IDX) ? 3'd0 : word_idx_q + 3'd1;
          if (word_idx_q == LAST_WORD_IDX) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // Config wins ties; frames are only started from here, which keeps them atomic.
        if (bus.cfg_req) begin
          cfg_grant  = 1'b1;
          cfg_word_d = {4'b0000, bus.cfg_addr, bus.cfg_data};
          state_d    = ST_CFG;
        end else if (frame_pend_q) begin
          frame_grant  = 1'b1;
          frame_pend_d = 1'b0;
          word_idx_d   = 3'd0;
          state_d      = ST_FRAME;
        end
      end
      ST_CFG: begin
        issue_valid = 1'b1;
        issue_word  = cfg_word_q;
        if (issue_done) state_d = ST_IDLE;
      end
      ST_FRAME: begin
        issue_valid = 1'b1;
        issue_word  = frame_word;
        if (issue_done) begin
          word_idx_d = (word_idx_q == LAST_WORD_IDX) ? 3'd0 : word_idx_q + 3'd1;
          if (word_idx_q == LAST_WORD_IDX) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q      <= ST_INIT;
      word_idx_q   <= 3'd0;
      frame_pend_q <= 1'b0;
      cfg_word_q   <= 16'h0000;
      frame_tick_q <= 1'b0;
      cfg_ack_q    <= 1'b0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_drop_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'h0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      frame_pend_q <= frame_pend_d;
      cfg_word_q   <= cfg_word_d;
      frame_tick_q <= frame_tick_i;
      cfg_ack_q    <= cfg_grant;
      init_done_q  <= init_done_q | (state_q == ST_INIT && issue_done && word_idx_q == LAST_WORD_IDX);
      busy_q       <= (state_d != ST_IDLE);
      frame_drop_q <= tick_rise & frame_pend_q;
      if (frame_grant) begin
        for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_in[i];
      end
    end
  end

  max7219_display_scheduler_spi_word_issuer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_issuer (
    .clk           (clk),
    .res           (res),
    .issue_valid_i (issue_valid),
    .issue_word_i  (issue_word),
    .issue_done_o  (issue_done),
    .spi_ready_i   (bus.spi_ready),
    .spi_sent_i    (bus.spi_sent),
    .spi_word_o    (bus.spi_word),
    .spi_cs_o      (bus.spi_cs)
  );

  assign bus.cfg_ack   = cfg_ack_q;
  assign init_done_o   = init_done_q;
  assign busy_o        = busy_q;
  assign frame_drop_o  = frame_drop_q;

endmodule

// File: tb/tb_max7219_display_scheduler.sv
// Scoreboard bench: stimulus pushes hand-computed SPI words, a monitor pops them as cs falls.
module tb_max7219_display_scheduler;

  typedef struct {
    logic [15:0] word;
    bit          check_gap;
  } exp_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic frame_tick = 1'b0;
  logic frame_ena  = 1'b1;
  logic [3:0] ces_0X = 4'h0, ces_X0 = 4'h0, sec_0X = 4'h0, min_0X = 4'h0;
  logic [2:0] sec_X0 = 3'd0, min_X0 = 3'd0;
  logic init_done, busy, frame_drop;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   words_seen = 0;
  int   ack_count = 0;
  int   drop_count = 0;
  int   shift_cnt = 0;

  max7219_display_scheduler_if bus ();

  max7219_display_scheduler dut (
    .clk          (clk),
    .res          (res),
    .frame_tick_i (frame_tick),
    .frame_ena_i  (frame_ena),
    .ces_0X_i     (ces_0X),
    .ces_X0_i     (ces_X0),
    .sec_0X_i     (sec_0X),
    .sec_X0_i     (sec_X0),
    .min_0X_i     (min_0X),
    .min_X0_i     (min_X0),
    .bus          (bus),
    .init_done_o  (init_done),
    .busy_o       (busy),
    .frame_drop_o (frame_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push1(input logic [15:0] w, input bit gap);
    exp_t e;
    e.word = w;
    e.check_gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push6(input logic [15:0] w0, w1, w2, w3, w4, w5);
    push1(w0, 1'b0); push1(w1, 1'b1); push1(w2, 1'b1);
    push1(w3, 1'b1); push1(w4, 1'b1); push1(w5, 1'b1);
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, input logic [2:0] d,
                            input logic [3:0] e, input logic [2:0] f);
    ces_0X = a; ces_X0 = b; sec_0X = c; sec_X0 = d; min_0X = e; min_X0 = f;
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy || (exp_q.size() != 0)}, 32'd0);
  endtask

  task automatic wait_init(input string name, input int budget);
    int n = 0;
    while (!init_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_init_done"}, {31'd0, init_done}, 32'd1);
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({name, "_words_left"}, exp_q.size(), 32'd0);
  endtask

  // SPI master model: always ready, 64 cycles of shifting, then a one-cycle sent pulse.
  initial begin
    bus.spi_ready = 1'b1;
    bus.spi_sent  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.spi_sent) begin
        bus.spi_sent = 1'b0;
        shift_cnt = 0;
      end else if (!res && bus.spi_cs == 1'b0) begin
        shift_cnt++;
        if (shift_cnt == 64) bus.spi_sent = 1'b1;
      end else begin
        shift_cnt = 0;
      end
    end
  end

  // Monitor: one scoreboard pop per word start, plus gap and stability checks.
  initial begin
    logic        prev_cs = 1'b1;
    logic [15:0] held = 16'h0000;
    int          gap = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (bus.cfg_ack) ack_count++;
      if (frame_drop)  drop_count++;
      if (res) begin
        prev_cs = 1'b1;
        gap = 0;
      end else begin
        if (prev_cs && !bus.spi_cs) begin
          words_seen++;
          held = bus.spi_word;
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_word: got %04h, required no word", bus.spi_word);
          end else begin
            e = exp_q.pop_front();
            $display("[TB] word %04h (required %04h, gap %0d)", bus.spi_word, e.word, gap);
            check("spi_word", {16'd0, bus.spi_word}, {16'd0, e.word});
            if (e.check_gap) check("gap_cycles", gap, 32'd32);
          end
          gap = 0;
        end else if (!bus.spi_cs) begin
          check("word_stable", {16'd0, bus.spi_word}, {16'd0, held});
        end else begin
          gap++;
        end
        prev_cs = bus.spi_cs;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0, n, base, cs_low, busy_seen;
    bus.cfg_req  = 1'b0;
    bus.cfg_addr = 4'h0;
    bus.cfg_data = 8'h00;

    // 1: reset state, then the init sequence
    repeat (4) @(negedge clk);
    check("rst_cs", {31'd0, bus.spi_cs}, 32'd1);
    check("rst_word", {16'd0, bus.spi_word}, 32'd0);
    check("rst_cfg_ack", {31'd0, bus.cfg_ack}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_drop", {31'd0, frame_drop}, 32'd0);
    push6(16'h0C00, 16'h0F00, 16'h0B05, 16'h0A08, 16'h09FF, 16'h0C01);
    res = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_init_done", {31'd0, init_done}, 32'd0);
    check("mid_init_busy", {31'd0, busy}, 32'd1);
    wait_init("init", 2000);

    // 2: one frame with a plain digit pattern
    set_digits(4'd1, 4'd2, 4'd3, 3'd4, 4'd5, 3'd5);
    push6(16'h0101, 16'h0202, 16'h0383, 16'h0404, 16'h0585, 16'h0605);
    tick();
    wait_idle("frame1_idle", 2000);

    // 3: cfg request and tick in the same idle cycle
    set_digits(4'd9, 4'd8, 4'd2, 3'd5, 4'd1, 3'd3);
    push1(16'h0A03, 1'b0);
    push6(16'h0109, 16'h0208, 16'h0382, 16'h0405, 16'h0581, 16'h0603);
    a0 = ack_count;
    @(negedge clk);
    bus.cfg_req = 1'b1; bus.cfg_addr = 4'hA; bus.cfg_data = 8'h03; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n = 0;
    while (!bus.cfg_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("cfg_ack_seen", {31'd0, bus.cfg_ack}, 32'd1);
    bus.cfg_req = 1'b0;
    wait_idle("cfg_frame_idle", 3000);
    check("cfg_ack_pulses", ack_count - a0, 32'd1);

    // 4: three ticks in one frame; digits change after the first grant (snapshot + pass-through)
    set_digits(4'hF, 4'd5, 4'd0, 3'd7, 4'd9, 3'd6);
    push6(16'h010F, 16'h0205, 16'h0380, 16'h0407, 16'h0589, 16'h0606);
    push6(16'h0101, 16'h0202, 16'h0383, 16'h0404, 16'h0585, 16'h0606);
    d0 = drop_count;
    tick();
    repeat (5) @(negedge clk);
    set_digits(4'd1, 4'd2, 4'd3, 3'd4, 4'd5, 3'd6);
    tick();
    repeat (5) @(negedge clk);
    check("no_drop_second_tick", drop_count - d0, 32'd0);
    tick();
    wait_idle("two_frames_idle", 4000);
    check("frame_drop_pulses", drop_count - d0, 32'd1);

    // 5: frame_ena low freezes the display
    set_digits(4'd0, 4'd0, 4'd9, 3'd5, 4'd9, 3'd5);
    frame_ena = 1'b0;
    d0 = drop_count;
    cs_low = 0;
    busy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      repeat (20) begin
        @(negedge clk);
        if (!bus.spi_cs) cs_low++;
        if (busy) busy_seen++;
      end
    end
    check("ena0_cs_low", cs_low, 32'd0);
    check("ena0_busy", busy_seen, 32'd0);
    check("ena0_drop", drop_count - d0, 32'd0);
    frame_ena = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.spi_cs) cs_low++;
    end
    check("ena1_no_stale_frame", cs_low, 32'd0);
    push6(16'h0100, 16'h0200, 16'h0389, 16'h0405, 16'h0589, 16'h0605);
    tick();
    wait_idle("ena1_frame_idle", 2000);

    // 6: asynchronous reset during the third frame word, then init again
    push1(16'h0100, 1'b0); push1(16'h0200, 1'b1); push1(16'h0389, 1'b1);
    base = words_seen;
    tick();
    n = 0;
    while (words_seen < base + 3 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("third_word_reached", {31'd0, words_seen >= base + 3}, 32'd1);
    res = 1'b1;
    #1;
    check("async_rst_cs", {31'd0, bus.spi_cs}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_word_zero", {16'd0, bus.spi_word}, 32'd0);
    check("rst_init_cleared", {31'd0, init_done}, 32'd0);
    push6(16'h0C00, 16'h0F00, 16'h0B05, 16'h0A08, 16'h09FF, 16'h0C01);
    res = 1'b0;
    wait_init("reinit", 2000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
